// File: rtl/branch_pkg.sv
// Shared definitions for the branch redirect controller: FSM encoding and
// the layout of one in-flight branch record.
package branch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REDIR = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // One in-flight branch: predicted direction plus both candidate PCs.
  localparam int ENTRY_W = 65;

  typedef struct packed {
    logic        pred;
    logic [31:0] fallthru;
    logic [31:0] target;
  } br_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Synchronous FIFO of in-flight branch records, oldest at the head.
// A synchronous clear empties it in one cycle and overrides push/pop.
module branch_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Tracks predicted branches from IF until they resolve in EX. A resolved
// direction that disagrees with the prediction raises a one-cycle redirect to
// the correct PC, flushes IF/ID for two cycles and discards younger entries.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_branch,
  input  logic              if_pred,
  input  logic [31:0]       if_fallthru,
  input  logic [31:0]       if_target,
  input  logic              ex_resolve,
  input  logic              ex_taken,
  output logic              pre_wrong,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic              stall_req,
  output logic [CNT_W-1:0]  mispredict_cnt,
  output logic              err_underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]          state;
  logic                idle_run;
  logic                pop_req;
  logic                mismatch;
  logic                push_req;
  br_entry_t           wr_entry;
  br_entry_t           head;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  // Push/pop decisions are only taken in IDLE with the pipeline moving.
  assign idle_run = (state == ST_IDLE) && !stall;
  assign head     = fifo_dout;
  assign pop_req  = idle_run && ex_resolve && !fifo_empty;
  assign mismatch = pop_req && (ex_taken != head.pred);
  // A mispredict wipes the FIFO, so a same-cycle push is wrong-path and dropped.
  assign push_req = idle_run && if_branch && !mismatch && (!fifo_full || pop_req);

  assign wr_entry = '{pred: if_pred, fallthru: if_fallthru, target: if_target};

  assign flush     = (state == ST_REDIR) || (state == ST_FLUSH);
  assign stall_req = (fifo_count == FULL_CNT);

  branch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mismatch),
    .push  (push_req),
    .pop   (pop_req),
    .din   (wr_entry),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Redirect sequencing: IDLE -> REDIR -> FLUSH -> IDLE, frozen by stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (!stall) begin
      case (state)
        ST_IDLE:  state <= mismatch ? ST_REDIR : ST_IDLE;
        ST_REDIR: state <= ST_FLUSH;
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Single-cycle mispredict pulses; they never stretch even if REDIR is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_wrong      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      pre_wrong      <= mismatch;
      redirect_valid <= mismatch;
    end
  end

  // Corrected fetch PC, captured at the mispredicting pop and held afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_pc <= '0;
    end else if (mismatch) begin
      redirect_pc <= ex_taken ? head.target : head.fallthru;
    end
  end

  // Saturating mispredict statistic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (mismatch && (mispredict_cnt != {CNT_W{1'b1}})) begin
      mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  // Sticky flag for a resolve arriving with nothing in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (idle_run && ex_resolve && fifo_empty) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus randomized bench for branch_redirect_ctrl against a
// queue-based model of in-flight branches and a redirect countdown.
module tb_branch_redirect_ctrl;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              if_branch;
  logic              if_pred;
  logic [31:0]       if_fallthru;
  logic [31:0]       if_target;
  logic              ex_resolve;
  logic              ex_taken;
  logic              pre_wrong;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              flush;
  logic              stall_req;
  logic [CNT_W-1:0]  mispredict_cnt;
  logic              err_underflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          pred;
    logic [31:0] ft;
    logic [31:0] tg;
  } ent_t;

  ent_t        q[$];
  int          redir_left;
  bit          exp_pw;
  bit          exp_rv;
  logic [31:0] exp_pc;
  int          exp_cnt;
  bit          exp_err;

  branch_redirect_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .if_branch      (if_branch),
    .if_pred        (if_pred),
    .if_fallthru    (if_fallthru),
    .if_target      (if_target),
    .ex_resolve     (ex_resolve),
    .ex_taken       (ex_taken),
    .pre_wrong      (pre_wrong),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall_req      (stall_req),
    .mispredict_cnt (mispredict_cnt),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the pre-edge inputs.
  task automatic model();
    bit   popped;
    bit   can_push;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      redir_left = 0;
      exp_pw = 0; exp_rv = 0; exp_pc = 0; exp_cnt = 0; exp_err = 0;
      return;
    end
    exp_pw = 0;
    exp_rv = 0;
    if (stall) return;
    if (redir_left > 0) begin
      redir_left--;
      return;
    end
    popped = 0;
    if (ex_resolve) begin
      if (q.size() == 0) begin
        exp_err = 1;
      end else if (ex_taken != q[0].pred) begin
        exp_pc = ex_taken ? q[0].tg : q[0].ft;
        exp_pw = 1;
        exp_rv = 1;
        if (exp_cnt < CNT_MAX) exp_cnt++;
        q.delete();
        redir_left = 2;
        return;
      end else begin
        popped = 1;
      end
    end
    can_push = (q.size() < DEPTH) || popped;
    if (popped) void'(q.pop_front());
    if (if_branch && can_push) begin
      e.pred = if_pred; e.ft = if_fallthru; e.tg = if_target;
      q.push_back(e);
    end
  endtask

  task automatic step(input string tag, input bit rn, input bit st, input bit br, input bit pr,
                      input logic [31:0] ft, input logic [31:0] tg, input bit rs, input bit tk);
    rst_n = rn; stall = st; if_branch = br; if_pred = pr;
    if_fallthru = ft; if_target = tg; ex_resolve = rs; ex_taken = tk;
    model();
    @(posedge clk);
    #1;
    chk({tag, ".pre_wrong"},      32'(pre_wrong),      32'(exp_pw));
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(exp_rv));
    chk({tag, ".redirect_pc"},    redirect_pc,         exp_pc);
    chk({tag, ".flush"},          32'(flush),          32'(redir_left > 0));
    chk({tag, ".stall_req"},      32'(stall_req),      32'(q.size() == DEPTH));
    chk({tag, ".cnt"},            32'(mispredict_cnt), 32'(exp_cnt));
    chk({tag, ".err_underflow"},  32'(err_underflow),  32'(exp_err));
    chk({tag, ".fifo_count"},     32'(dut.u_fifo.count), 32'(q.size()));
  endtask

  task automatic push(input string tag, input bit pr, input logic [31:0] pc, input logic [31:0] tg);
    step(tag, 1, 0, 1, pr, pc + 32'd4, tg, 0, 0);
  endtask

  task automatic resolve(input string tag, input bit tk);
    step(tag, 1, 0, 0, 0, 32'h0, 32'h0, 1, tk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    rst_n = 0; stall = 0; if_branch = 0; if_pred = 0;
    if_fallthru = 0; if_target = 0; ex_resolve = 0; ex_taken = 0;

    // Reset state
    step("reset0", 0, 1, 1, 1, 32'h1, 32'h2, 1, 1);
    step("reset1", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

    // Correctly predicted taken branch
    push("m.push", 1, 32'h100, 32'h200);
    resolve("m.res", 1);
    chk("match.cnt_zero", 32'(mispredict_cnt), 32'd0);
    chk("match.no_pulse", 32'(pre_wrong), 32'd0);

    // Mispredicted: actually not taken -> fall-through
    push("mp.push", 1, 32'h100, 32'h200);
    resolve("mp.res", 0);
    chk("mp.redirect_pc", redirect_pc, 32'h104);
    chk("mp.pre_wrong", 32'(pre_wrong), 32'd1);
    chk("mp.flush1", 32'(flush), 32'd1);
    idle("mp.redir");
    chk("mp.flush2", 32'(flush), 32'd1);
    chk("mp.pulse_gone", 32'(redirect_valid), 32'd0);
    idle("mp.flush");
    chk("mp.flush_end", 32'(flush), 32'd0);
    chk("mp.cnt_one", 32'(mispredict_cnt), 32'd1);

    // Fill to full, fifth push dropped, matching resolve frees a slot
    for (int i = 0; i < 4; i++) push("full.push", 1, 32'h300 + 32'(i * 16), 32'h400);
    chk("full.stall_req", 32'(stall_req), 32'd1);
    push("full.push5", 0, 32'h380, 32'h480);
    resolve("full.res", 1);
    chk("full.stall_req_clr", 32'(stall_req), 32'd0);
    // Push + matching pop while not full keeps the count
    step("pp.same", 1, 0, 1, 1, 32'h504, 32'h600, 1, 1);
    // Full, push + mismatching pop: everything discarded
    push("pp.fill", 1, 32'h700, 32'h800);
    step("pp.mis", 1, 0, 1, 1, 32'h904, 32'ha00, 1, 0);
    chk("pp.cleared", 32'(dut.u_fifo.count), 32'd0);
    idle("pp.i1");
    idle("pp.i2");

    // Oldest of three mispredicts: younger two are discarded
    push("yng.p0", 0, 32'h1000, 32'h2000);
    push("yng.p1", 1, 32'h1010, 32'h2010);
    push("yng.p2", 1, 32'h1020, 32'h2020);
    resolve("yng.res", 1);
    chk("yng.redirect_pc", redirect_pc, 32'h2000);
    idle("yng.i1");
    idle("yng.i2");
    // Nothing left to pop -> underflow, sticky
    resolve("uf.res", 1);
    chk("uf.err", 32'(err_underflow), 32'd1);
    for (int i = 0; i < 3; i++) push("uf.hold", 1, 32'h40, 32'h80);
    chk("uf.sticky", 32'(err_underflow), 32'd1);
    step("uf.rst", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("uf.cleared", 32'(err_underflow), 32'd0);

    // Stall held in REDIR, reset mid-FLUSH
    push("st.push", 1, 32'hc00, 32'hd00);
    resolve("st.res", 0);
    for (int i = 0; i < 3; i++) step("st.hold", 1, 1, 1, 1, 32'h4, 32'h8, 1, 0);
    chk("st.flush_held", 32'(flush), 32'd1);
    chk("st.pc_held", redirect_pc, 32'hc04);
    idle("st.to_flush");
    step("st.rst_mid_flush", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("st.rst_flush", 32'(flush), 32'd0);
    chk("st.rst_pc", redirect_pc, 32'd0);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      push("sat.push", 1, 32'h10 * 32'(i), 32'h20);
      resolve("sat.res", 0);
      idle("sat.i1");
      idle("sat.i2");
    end
    chk("sat.cnt", 32'(mispredict_cnt), 32'(CNT_MAX));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step("rnd",
           ($urandom_range(255) != 0),
           ($urandom_range(5) == 0),
           ($urandom_range(1) == 1),
           ($urandom_range(1) == 1),
           $urandom(),
           $urandom(),
           ($urandom_range(2) == 0),
           ($urandom_range(1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
